branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. It sits upstream of the PMIPSL1 fetch stage and supplies the predicted next PC for the instruction at the current fetch address. It is trained by branch outcomes resolved in the pipeline, and it keeps saturating branch and mispredict statistics for debug.

---
 rtl/bp_pkg.sv | 20 ++
 rtl/branch_predictor_sat_ctr2.sv | 24 ++
 rtl/branch_predictor.sv | 99 +++++++++
 tb/tb_branch_predictor.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor slice.
//   PC_W           : program counter width
//   INDEX_BITS_DEF : default log2 of the BTB entry count
//   ctr_t          : 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   CTR_RST        : counter value loaded into every entry on reset
package bp_pkg;

    localparam int unsigned PC_W           = 16;
    localparam int unsigned INDEX_BITS_DEF = 3;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RST = WNT;

endpackage

// File: rtl/branch_predictor_sat_ctr2.sv
// sat_ctr2: next-state logic for a 2-bit saturating direction counter.
//   ctr      in  current counter value
//   taken    in  resolved branch direction
//   ctr_next out counter after training (saturates at SNT and ST)
module sat_ctr2
    import bp_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        unique case (ctr)
            SNT: ctr_next = taken ? WNT : SNT;
            WNT: ctr_next = taken ? WT  : SNT;
            WT:  ctr_next = taken ? ST  : WNT;
            ST:  ctr_next = taken ? ST  : WT;
            default: ctr_next = ctr;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters.
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   if_pc           : fetch PC for the combinational lookup
//   pred_taken      : lookup hit with counter predicting taken
//   pred_next_pc    : stored target when predicted taken, else if_pc + 2
//   upd_*           : resolved-branch training port (sampled when upd_valid)
//   branch_cnt      : saturating count of resolved branches
//   mispred_cnt     : saturating count of mispredicted branches
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_next_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_mispredict,
    output logic [PC_W-1:0] branch_cnt,
    output logic [PC_W-1:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W   = PC_W - INDEX_BITS - 1;

    logic            valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [PC_W-1:0] target_q [ENTRIES];
    ctr_t            ctr_q    [ENTRIES];

    // Lookup: bit 0 of the PC is never part of index or tag.
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]      if_tag;
    logic                  if_hit;

    assign if_idx = if_pc[INDEX_BITS:1];
    assign if_tag = if_pc[PC_W-1:INDEX_BITS+1];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign pred_taken   = if_hit && ctr_q[if_idx][1];
    assign pred_next_pc = pred_taken ? target_q[if_idx] : if_pc + PC_W'(2);

    // Training
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  upd_hit;
    ctr_t                  upd_ctr_next;

    assign upd_idx = upd_pc[INDEX_BITS:1];
    assign upd_tag = upd_pc[PC_W-1:INDEX_BITS+1];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_ctr2 u_sat_ctr2 (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (upd_taken)
                    target_q[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                // Taken miss replaces whatever lives at this index.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= WT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            if (branch_cnt != '1)
                branch_cnt <= branch_cnt + PC_W'(1);
            if (upd_mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + PC_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] if_pc;
    logic        pred_taken;
    logic [15:0] pred_next_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    branch_predictor #(.INDEX_BITS(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_next_pc   (pred_next_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one resolved branch for exactly one clock edge.
    task automatic do_upd(input logic [15:0] pc, input logic taken,
                          input logic [15:0] tgt, input logic mis);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_mispredict = mis;
        @(posedge clock);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic look(input string tag, input logic [15:0] pc,
                        input logic exp_t, input logic [15:0] exp_pc);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {15'd0, pred_taken}, {15'd0, exp_t});
        check({tag, "_next"}, pred_next_pc, exp_pc);
    endtask

    initial begin
        reset = 1'b1;
        if_pc = 16'h0010;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        look("rst", 16'h0010, 1'b0, 16'h0012);
        check("rst_bcnt", branch_cnt, 16'd0);
        check("rst_mcnt", mispred_cnt, 16'd0);

        // Same-cycle collision: lookup sees pre-update state
        if_pc = 16'h0010;
        upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1;
        upd_target = 16'h0040; upd_mispredict = 1'b0;
        #1;
        check("coll_before", {15'd0, pred_taken}, 16'd0);
        @(posedge clock);
        #1 upd_valid = 1'b0;
        look("coll_after", 16'h0010, 1'b1, 16'h0040);
        check("bcnt_1", branch_cnt, 16'd1);

        // Two not-taken: WT -> WNT -> SNT
        do_upd(16'h0010, 1'b0, 16'h0000, 1'b1);
        look("nt1", 16'h0010, 1'b0, 16'h0012);
        do_upd(16'h0010, 1'b0, 16'h0000, 1'b0);
        look("nt2", 16'h0010, 1'b0, 16'h0012);
        check("bcnt_3", branch_cnt, 16'd3);
        check("mcnt_1", mispred_cnt, 16'd1);

        // Five taken from SNT: 01,10,11,11,11; last one retargets
        do_upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        look("t1_wnt", 16'h0010, 1'b0, 16'h0012);
        do_upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        do_upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        do_upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        do_upd(16'h0010, 1'b1, 16'h0044, 1'b0);
        look("t5_st", 16'h0010, 1'b1, 16'h0044);
        // ST -> WT, target kept
        do_upd(16'h0010, 1'b0, 16'h0000, 1'b1);
        look("st_nt", 16'h0010, 1'b1, 16'h0044);
        check("bcnt_9", branch_cnt, 16'd9);
        check("mcnt_2", mispred_cnt, 16'd2);

        // Alias at index 0
        do_upd(16'h0010, 1'b1, 16'h0040, 1'b0);
        look("alias_pre", 16'h0010, 1'b1, 16'h0040);
        do_upd(16'h0020, 1'b1, 16'h0080, 1'b0);
        look("alias_old", 16'h0010, 1'b0, 16'h0012);
        look("alias_new", 16'h0020, 1'b1, 16'h0080);
        look("alias_bit0", 16'h0021, 1'b1, 16'h0080);

        // Miss not-taken leaves table alone (same index, other tag)
        do_upd(16'h0030, 1'b0, 16'h1234, 1'b0);
        look("mnt_keep", 16'h0020, 1'b1, 16'h0080);
        look("mnt_cold", 16'h0030, 1'b0, 16'h0032);
        check("bcnt_12", branch_cnt, 16'd12);

        // Mispredict ignored without upd_valid
        upd_mispredict = 1'b1;
        @(posedge clock);
        #1 upd_mispredict = 1'b0;
        check("mis_novalid", mispred_cnt, 16'd2);
        check("bcnt_novalid", branch_cnt, 16'd12);

        // Wrap of the fall-through PC
        look("wrap", 16'hFFFE, 1'b0, 16'h0000);

        // Statistic saturation (cold-miss not-taken updates)
        for (int i = 0; i < 65540; i++)
            do_upd(16'h0032, 1'b0, 16'h0000, 1'b1);
        check("bcnt_sat", branch_cnt, 16'hFFFF);
        check("mcnt_sat", mispred_cnt, 16'hFFFF);
        do_upd(16'h0032, 1'b0, 16'h0000, 1'b1);
        check("bcnt_sat2", branch_cnt, 16'hFFFF);
        check("mcnt_sat2", mispred_cnt, 16'hFFFF);
        look("sat_keep", 16'h0020, 1'b1, 16'h0080);

        // Asynchronous reset between edges, with an update in flight
        @(posedge clock);
        #1;
        upd_valid = 1'b1; upd_pc = 16'h0040; upd_taken = 1'b1;
        upd_target = 16'h0100; upd_mispredict = 1'b1;
        if_pc = 16'h0020;
        #1;
        check("pre_arst", {15'd0, pred_taken}, 16'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_taken", {15'd0, pred_taken}, 16'd0);
        check("arst_next", pred_next_pc, 16'h0022);
        check("arst_bcnt", branch_cnt, 16'd0);
        check("arst_mcnt", mispred_cnt, 16'd0);
        @(posedge clock);
        #1;
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        reset = 1'b0;
        look("arst_drop", 16'h0040, 1'b0, 16'h0042);
        check("arst_bcnt2", branch_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
